crc32_stream: RTL and testbench

Parametrised streaming CRC-32 engine for the Ethernet MAC datapath. It consumes DATA_W-bit beats with frame delimiters and a byte count on the final beat, and it supports 8-, 16-, 32- or 64-bit datapaths. Its byte-serial arithmetic is identical to the existing byte-wide CRC block. On each frame end it reports the final register, the transmit FCS and a residue-match flag, so one instance serves both TX FCS generation and RX FCS checking.

---
 rtl/crc32_stream.sv | 134 +++++++++++++
 tb/tb_crc32_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream.sv
// ============================================================================
// crc32_stream : streaming CRC-32 (poly 04C11DB7, MSB-first) over DATA_W beats
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module crc32_stream #(
  parameter int          DATA_W  = 8,
  parameter logic [31:0] INIT    = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE = 32'hC704_DD7B
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             s_valid,
  input  logic                                             s_sop,
  input  logic                                             s_last,
  input  logic [((DATA_W/8) > 1 ? $clog2(DATA_W/8) : 1)-1:0] s_bytes,
  input  logic [DATA_W-1:0]                                s_data,
  input  logic                                             clear,
  output logic [31:0]                                      crc,
  output logic [31:0]                                      fcs,
  output logic                                             crc_valid,
  output logic                                             crc_match,
  output logic                                             busy,
  output logic                                             err_nosop
);

  localparam int          NBYTES = DATA_W / 8;
  localparam int          BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int          NSEL_W = BW + 1;
  localparam logic [31:0] POLY   = 32'h04C1_1DB7;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] snap_q, snap_d;
  logic        crc_valid_q, crc_valid_d;
  logic        err_nosop_q, err_nosop_d;

  logic [31:0]       base_crc;
  logic [31:0]       lane_crc;
  logic [31:0]       next_crc;
  logic [NSEL_W-1:0] n_sel;

  function automatic logic [31:0] crc_byte(input logic [31:0] r, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = r;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  // Number of bytes folded in this beat: all lanes unless this is a short last beat.
  always_comb begin
    n_sel = NSEL_W'(NBYTES);
    if (s_last && (NBYTES > 1)) n_sel = {1'b0, s_bytes} + NSEL_W'(1);
  end

  assign base_crc = s_sop ? INIT : crc_q;

  // Byte-serial chain; each tap is the register after lanes 0..k.
  always_comb begin
    lane_crc = base_crc;
    next_crc = base_crc;
    for (int k = 0; k < NBYTES; k++) begin
      lane_crc = crc_byte(lane_crc, s_data[8*k +: 8]);
      if (n_sel == NSEL_W'(k + 1)) next_crc = lane_crc;
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    snap_d      = snap_q;
    crc_valid_d = 1'b0;
    err_nosop_d = 1'b0;
    if (clear) begin
      crc_d   = INIT;
      state_d = S_IDLE;
    end else if (s_valid) begin
      if (s_sop || (state_q == S_ACTIVE)) begin
        crc_d = next_crc;
        if (s_last) begin
          snap_d      = next_crc;
          crc_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_ACTIVE;
        end
      end else begin
        err_nosop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      crc_q       <= INIT;
      snap_q      <= INIT;
      crc_valid_q <= 1'b0;
      err_nosop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      snap_q      <= snap_d;
      crc_valid_q <= crc_valid_d;
      err_nosop_q <= err_nosop_d;
    end
  end

  // The snapshot is shown while crc_valid is high so back-to-back frames report cleanly.
  assign crc       = crc_valid_q ? snap_q : crc_q;
  assign crc_match = (crc == RESIDUE);
  assign crc_valid = crc_valid_q;
  assign err_nosop = err_nosop_q;
  assign busy      = (state_q == S_ACTIVE);

  always_comb begin
    fcs = '0;
    for (int i = 0; i < 32; i++) fcs[i] = ~crc[31-i];
  end

endmodule

`default_nettype wire

// File: tb/tb_crc32_stream.sv
// ============================================================================
// tb_crc32_stream : scoreboard bench for crc32_stream (DATA_W=32)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_crc32_stream;

  localparam int          DW      = 32;
  localparam int          NB      = DW / 8;
  localparam int          BW      = 2;
  localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] POLY    = 32'h04C1_1DB7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_sop = 1'b0;
  logic          s_last = 1'b0;
  logic [BW-1:0] s_bytes = '0;
  logic [DW-1:0] s_data = '0;
  logic          clear = 1'b0;
  logic [31:0]   crc, fcs;
  logic          crc_valid, crc_match, busy, err_nosop;

  crc32_stream #(.DATA_W(DW), .INIT(INIT), .RESIDUE(RESIDUE)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sop(s_sop), .s_last(s_last),
    .s_bytes(s_bytes), .s_data(s_data), .clear(clear), .crc(crc), .fcs(fcs),
    .crc_valid(crc_valid), .crc_match(crc_match), .busy(busy), .err_nosop(err_nosop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] crc;
    logic [31:0] fcs;
    logic        match;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  frm[$];
  logic [31:0] tbl[256];
  int n_cmp = 0, n_fail = 0;
  int err_exp = 0, err_seen = 0;
  logic [31:0] last_good;
  logic [31:0] tmp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Table-driven MSB-first CRC over the whole frame queue.
  function automatic logic [31:0] crc_ref();
    logic [31:0] r = INIT;
    foreach (frm[i]) r = (r << 8) ^ tbl[r[31:24] ^ frm[i]];
    return r;
  endfunction

  function automatic logic [31:0] fcs_of(input logic [31:0] c);
    logic [31:0] f;
    for (int i = 0; i < 32; i++) f[i] = ~c[31-i];
    return f;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = b[7-i];
    return o;
  endfunction

  task automatic push_exp(input logic [31:0] c, input logic [31:0] f, input logic m);
    exp_t e;
    e.crc = c; e.fcs = f; e.match = m;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic sop, input logic last, input logic [BW-1:0] nb,
                      input logic [DW-1:0] d, input logic clr);
    s_valid = 1'b1; s_sop = sop; s_last = last; s_bytes = nb; s_data = d; clear = clr;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0; s_bytes = '0; s_data = DW'($urandom); clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Sends frm as beats; with only_first set, stops after the opening beat.
  task automatic send_frm(input bit push, input bit only_first);
    int n = frm.size();
    logic [DW-1:0] d;
    int cnt;
    bit last;
    for (int i = 0; i < n; i += NB) begin
      d    = DW'($urandom);
      cnt  = (n - i < NB) ? n - i : NB;
      for (int k = 0; k < cnt; k++) d[8*k +: 8] = frm[i+k];
      last = (i + NB >= n);
      if (last && push) push_exp(crc_ref(), fcs_of(crc_ref()), crc_ref() == RESIDUE);
      beat(i == 0, last, BW'(cnt - 1), d, 1'b0);
      if (only_first) return;
    end
  endtask

  task automatic rand_frm(input int len);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_nosop === 1'b1) err_seen++;
      if (crc_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_crc_valid: got pulse with crc %h, expected none", crc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_crc", crc, mon_e.crc);
          chk("sb_fcs", fcs, mon_e.fcs);
          chk("sb_match", 32'(crc_match), 32'(mon_e.match));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tmp = 32'(i) << 24;
      for (int j = 0; j < 8; j++) tmp = tmp[31] ? ((tmp << 1) ^ POLY) : (tmp << 1);
      tbl[i] = tmp;
    end

    // Reset state
    idle(2);
    chk("rst_crc", crc, INIT);
    chk("rst_fcs", fcs, 32'h0);
    chk("rst_valid", 32'(crc_valid), 0);
    chk("rst_match", 32'(crc_match), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_nosop), 0);
    rst_n = 1'b1;
    idle(2);

    // Check vector: bit-reversed "123456789"
    frm = {8'h8C, 8'h4C, 8'hCC, 8'h2C, 8'hAC, 8'h6C, 8'hEC, 8'h1C, 8'h9C};
    push_exp(32'h9B63_D02C, 32'hCBF4_3926, 1'b0);
    send_frm(1'b0, 1'b0);
    chk("kv_valid_after_beat3", 32'(crc_valid), 1);
    idle(1);
    chk("kv_valid_one_cycle", 32'(crc_valid), 0);
    chk("kv_crc_hold", crc, 32'h9B63_D02C);
    idle(2);

    // Good frame with FCS appended, then the same frame with one bit flipped
    rand_frm(64);
    tmp = fcs_of(crc_ref());
    for (int k = 0; k < 4; k++) frm.push_back(rev8(tmp[8*k +: 8]));
    send_frm(1'b1, 1'b0);
    idle(2);
    chk("residue_match", 32'(crc_match), 1);
    frm[17] = frm[17] ^ 8'h10;
    send_frm(1'b1, 1'b0);
    idle(2);
    chk("residue_flip_nomatch", 32'(crc_match), 0);

    // Back-to-back frames including single-beat frames
    for (int f = 0; f < 24; f++) begin
      rand_frm((f % 5 == 2) ? 3 : $urandom_range(1, 23));
      send_frm(1'b1, 1'b0);
    end
    last_good = crc_ref();
    idle(3);

    // Beat without s_sop while idle
    beat(1'b0, 1'b0, '0, DW'($urandom), 1'b0);
    err_exp++;
    chk("err_nosop_pulse", 32'(err_nosop), 1);
    chk("err_crc_unchanged", crc, last_good);
    chk("err_busy", 32'(busy), 0);
    idle(1);
    chk("err_nosop_one_cycle", 32'(err_nosop), 0);

    // s_sop mid-frame abandons the first frame
    rand_frm(10);
    send_frm(1'b0, 1'b1);
    chk("partial_busy", 32'(busy), 1);
    rand_frm(9);
    send_frm(1'b1, 1'b0);
    idle(3);

    // clear coincident with s_last
    rand_frm(8);
    send_frm(1'b0, 1'b1);
    beat(1'b0, 1'b1, 2'd3, DW'($urandom), 1'b1);
    chk("clr_no_valid", 32'(crc_valid), 0);
    chk("clr_crc", crc, INIT);
    chk("clr_busy", 32'(busy), 0);
    idle(2);

    // Asynchronous reset mid-frame
    rand_frm(12);
    send_frm(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_crc", crc, INIT);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_valid", 32'(crc_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    rand_frm(13);
    send_frm(1'b1, 1'b0);
    idle(4);

    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("err_count", 32'(err_seen), 32'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
